axi_sram_slave: RTL

AXI3 responder that serves single-beat and INCR-burst read/write transactions from a core-side AXI master (the CPU's SRAM-to-AXI bridge) out of a single-port synchronous SRAM. It sits on the slave side of the CPU's AXI interface, in place of the external memory model, for integrated simulation and FPGA test. It serves one transaction at a time, arbitrating between the read and write channels.

---
 rtl/axi_sram_slave_pkg.sv | 23 ++
 rtl/axi_sram_slave_if.sv | 67 ++++++
 rtl/axi_sram_slave_burst_addr.sv | 27 ++
 rtl/axi_sram_slave.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI response/burst codes and the responder state encoding.
// Latency: none (definitions only).
// Backpressure: not applicable.
package axi_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle between the CPU bridge and the SRAM responder.
// Latency: none (wires only).
// Backpressure: carried by the valid/ready pairs of each channel.
interface axi_sram_slave_if #(parameter int ID_W = 4);

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/axi_sram_slave_burst_addr.sv
// Next-beat address and SRAM range check for the current burst beat.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take next_addr.
module axi_burst_addr
    import axi_slave_pkg::*;
#(
    parameter int RAM_AW = 16
) (
    input  logic [31:0] cur_addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        in_range
);

    // FIXED bursts hammer one address; INCR and WRAP (and the reserved code) step by the beat size.
    always_comb begin
        next_addr = cur_addr;
        if (burst != BURST_FIXED) begin
            next_addr = cur_addr + (32'd1 << size);
        end
    end

    // Any set bit above the SRAM byte-address span means the beat misses the RAM.
    assign in_range = (cur_addr[31:RAM_AW+2] == '0);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder serving one read or write burst at a time out of a single-port SRAM.
// Latency: AR->ram_en 1 cycle, AR->rvalid 3 cycles, 3 cycles per further read beat; last W->bvalid 1 cycle.
// Backpressure: R/B outputs hold while rready/bready are low; the idle channel is not accepted until IDLE.
module axi_sram_slave
    import axi_slave_pkg::*;
#(
    parameter int RAM_AW = 16,
    parameter int ID_W   = 4
) (
    input  logic              aclk,
    input  logic              areset,
    axi_sram_slave_if.slave   axi,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t          state, state_nxt;
    logic [ID_W-1:0] id_q;
    logic [31:0]     cur_addr;
    logic [7:0]      len_q;
    logic [7:0]      beat_cnt;
    logic [2:0]      size_q;
    logic [1:0]      burst_q;
    logic            last_was_rd;
    logic            err_q;
    logic [31:0]     rdata_q;
    logic [1:0]      rresp_q;

    logic [31:0]     next_addr;
    logic            in_range;
    logic            idle, pick_wr, ar_hs, aw_hs, w_hs, last_beat;

    // wid/wlast carry no information here: write completion is counted in beats.
    logic unused_w;
    assign unused_w = ^{axi.wid, axi.wlast};

    axi_burst_addr #(.RAM_AW(RAM_AW)) u_addr (
        .cur_addr  (cur_addr),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr),
        .in_range  (in_range)
    );

    // Readies are also held low while reset is asserted so every handshake output reads 0 in reset.
    assign idle      = (state == IDLE) && !areset;
    assign pick_wr   = axi.awvalid && (!axi.arvalid || last_was_rd);
    assign ar_hs     = idle && axi.arvalid && !pick_wr;
    assign aw_hs     = idle && pick_wr;
    assign w_hs      = (state == WR_DATA) && axi.wvalid;
    assign last_beat = (beat_cnt == len_q);

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one transaction at a time, read wins ties unless it won the previous one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs) state_nxt = RD_ADDR;
                     else if (aw_hs) state_nxt = WR_DATA;
            RD_ADDR: state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = RD_DATA;
            RD_DATA: if (axi.rready) state_nxt = last_beat ? IDLE : RD_ADDR;
            WR_DATA: if (axi.wvalid && last_beat) state_nxt = WR_RESP;
            WR_RESP: if (axi.bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: handshakes and SRAM strobes from state; response payload straight from registers.
    always_comb begin
        axi.arready = idle && !pick_wr;
        axi.awready = idle && (pick_wr || !axi.arvalid);
        axi.wready  = (state == WR_DATA);
        axi.rvalid  = (state == RD_DATA);
        axi.rlast   = (state == RD_DATA) && last_beat;
        axi.rid     = id_q;
        axi.rdata   = rdata_q;
        axi.rresp   = rresp_q;
        axi.bvalid  = (state == WR_RESP);
        axi.bid     = id_q;
        axi.bresp   = err_q ? RESP_DECERR : RESP_OKAY;
        ram_en      = in_range && ((state == RD_ADDR) || w_hs);
        ram_we      = (w_hs && in_range) ? axi.wstrb : 4'b0;
        ram_addr    = cur_addr[RAM_AW+1:2];
        ram_wdata   = (state == WR_DATA) ? axi.wdata : 32'b0;
    end

    // Burst bookkeeping: latch the winning request, capture read data, step address per beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            id_q        <= '0;
            cur_addr    <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            last_was_rd <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    err_q    <= 1'b0;
                    beat_cnt <= '0;
                    if (ar_hs) begin
                        id_q        <= axi.arid;
                        cur_addr    <= axi.araddr;
                        len_q       <= axi.arlen;
                        size_q      <= axi.arsize;
                        burst_q     <= axi.arburst;
                        last_was_rd <= 1'b1;
                    end else if (aw_hs) begin
                        id_q        <= axi.awid;
                        cur_addr    <= axi.awaddr;
                        len_q       <= axi.awlen;
                        size_q      <= axi.awsize;
                        burst_q     <= axi.awburst;
                        last_was_rd <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    rdata_q <= in_range ? ram_rdata : 32'b0;
                    rresp_q <= in_range ? RESP_OKAY : RESP_DECERR;
                end
                RD_DATA: begin
                    if (axi.rready && !last_beat) begin
                        cur_addr <= next_addr;
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (!in_range) err_q <= 1'b1;
                        if (!last_beat) begin
                            cur_addr <= next_addr;
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
